// File: rtl/perf_counter_sampler_if.sv
// Sample-output handshake bundle for perf_counter_sampler: valid/ready plus the FIFO head payload.
interface perf_counter_sampler_if #(
  parameter int unsigned NUM_CNT     = 7,
  parameter int unsigned DELTA_WIDTH = 32
);
  logic                           sampleValid;
  logic                           sampleReady;
  logic [NUM_CNT*DELTA_WIDTH-1:0] sampleData;
  logic [15:0]                    sampleSeq;
  logic [31:0]                    sampleTime;

  modport master (output sampleValid, sampleData, sampleSeq, sampleTime, input sampleReady);
  modport slave  (input sampleValid, sampleData, sampleSeq, sampleTime, output sampleReady);
endinterface

// File: rtl/perf_counter_sampler.sv
// Periodically captures saturating per-counter deltas and queues them in a small sample FIFO.
// Optional macro PERF_SAMPLER_TIMESTAMP_EN adds a free-running cycle timestamp per entry.
module perf_counter_sampler #(
  parameter int unsigned NUM_CNT        = 7,
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned DELTA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned INTERVAL_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [NUM_CNT*CNT_WIDTH-1:0]     perfCounter_i,
  input  logic                             enable_i,
  input  logic [INTERVAL_WIDTH-1:0]        intervalCycles_i,
  perf_counter_sampler_if.master           smp,
  output logic                             dropped_o,
  output logic [$clog2(FIFO_DEPTH):0]      fifoCount_o
);
  localparam int unsigned DATA_W = NUM_CNT * DELTA_WIDTH;
  localparam int unsigned BASE_W = NUM_CNT * CNT_WIDTH;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] timer_q, timer_d, reload_c;
  logic [BASE_W-1:0]         base_q, base_d;
  logic [15:0]               seq_q, seq_d;
  logic                      dropped_q, dropped_d;
  logic [CNT_W-1:0]          count_q, count_d, wr_idx_c;
  logic                      valid_q, valid_d;
  logic [DATA_W-1:0]         data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]         data_d [FIFO_DEPTH];
  logic [15:0]               fseq_q [FIFO_DEPTH];
  logic [15:0]               fseq_d [FIFO_DEPTH];
  logic [DATA_W-1:0]         delta_c;
  logic                      tick_c, pop_c, full_c, push_c, drop_c;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
  logic [31:0]               ts_q;
  logic [31:0]               ftime_q [FIFO_DEPTH];
  logic [31:0]               ftime_d [FIFO_DEPTH];
`endif

  // Interval of 0 behaves as 1, so the reload value is max(interval,1)-1.
  assign reload_c = (intervalCycles_i == '0) ? '0 : intervalCycles_i - INTERVAL_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    base_d  = base_q;
    seq_d   = seq_q;
    tick_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = RUN;
          base_d  = perfCounter_i;
          timer_d = reload_c;
        end
      end
      RUN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - INTERVAL_WIDTH'(1);
        end else begin
          tick_c  = 1'b1;
          base_d  = perfCounter_i;
          timer_d = reload_c;
          seq_d   = seq_q + 16'd1;
        end
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Modular difference per counter, clamped to the delta width.
  always_comb begin
    delta_c = '0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      logic [CNT_WIDTH-1:0] diff;
      diff = perfCounter_i[i*CNT_WIDTH +: CNT_WIDTH] - base_q[i*CNT_WIDTH +: CNT_WIDTH];
      delta_c[i*DELTA_WIDTH +: DELTA_WIDTH] =
        (|diff[CNT_WIDTH-1:DELTA_WIDTH]) ? '1 : diff[DELTA_WIDTH-1:0];
    end
  end

  // Shift FIFO: entry 0 is always the head, so the outputs come straight from flops.
  always_comb begin
    pop_c     = valid_q && smp.sampleReady;
    full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    push_c    = tick_c && (!full_c || pop_c);
    drop_c    = tick_c && full_c && !pop_c;
    wr_idx_c  = count_q - CNT_W'(pop_c);
    count_d   = count_q - CNT_W'(pop_c) + CNT_W'(push_c);
    valid_d   = (count_d != '0);
    dropped_d = dropped_q | drop_c;
    data_d    = data_q;
    fseq_d    = fseq_q;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
    ftime_d   = ftime_q;
`endif
    if (pop_c) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        data_d[i] = data_q[i+1];
        fseq_d[i] = fseq_q[i+1];
`ifdef PERF_SAMPLER_TIMESTAMP_EN
        ftime_d[i] = ftime_q[i+1];
`endif
      end
      data_d[FIFO_DEPTH-1] = '0;
      fseq_d[FIFO_DEPTH-1] = '0;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
      ftime_d[FIFO_DEPTH-1] = '0;
`endif
    end
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (push_c && (CNT_W'(i) == wr_idx_c)) begin
        data_d[i] = delta_c;
        fseq_d[i] = seq_q;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
        ftime_d[i] = ts_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      base_q    <= '0;
      seq_q     <= '0;
      dropped_q <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        fseq_q[i] <= '0;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
        ftime_q[i] <= '0;
`endif
      end
`ifdef PERF_SAMPLER_TIMESTAMP_EN
      ts_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      base_q    <= base_d;
      seq_q     <= seq_d;
      dropped_q <= dropped_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      fseq_q    <= fseq_d;
`ifdef PERF_SAMPLER_TIMESTAMP_EN
      ftime_q   <= ftime_d;
      ts_q      <= ts_q + 32'd1;
`endif
    end
  end

  assign smp.sampleValid = valid_q;
  assign smp.sampleData  = data_q[0];
  assign smp.sampleSeq   = fseq_q[0];
`ifdef PERF_SAMPLER_TIMESTAMP_EN
  assign smp.sampleTime  = ftime_q[0];
`else
  assign smp.sampleTime  = 32'd0;
`endif
  assign dropped_o   = dropped_q;
  assign fifoCount_o = count_q;

endmodule
